clk_en_controller: RTL and testbench

// Run/halt/single-step controller for the core clock-enable. Generates a one-cycle
// clk_en strobe every DIV cycles of clk_in. Takes divide-ratio changes over a valid/ready

---
 rtl/clk_ctrl_pkg.sv | 8 +
 rtl/clk_en_counter.sv | 29 ++
 rtl/clk_en_controller.sv | 111 +++++++++++
 tb/tb_clk_en_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the clock-enable controller.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {RUN, HALTING, HALTED, STEP} clk_state_t;

    localparam int unsigned CLK_DIV_W_DEF = 8;

endpackage

// File: rtl/clk_en_counter.sv
// Loadable terminal-count counter: counts 0..div-1 while enabled, clr forces 0.
module clk_en_counter
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W = CLK_DIV_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;

    assign tc = (cnt == div - 1'b1);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_en_controller.sv
// Run/halt/single-step controller producing a divided one-cycle clock-enable strobe,
// with a valid/ready port for divide-ratio updates applied at period boundaries.
module clk_en_controller
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W       = CLK_DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = 2,
    parameter bit          START_RUN   = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             halt_req,
    input  logic             run_req,
    input  logic             step_req,
    output logic             clk_en,
    output logic             halted,
    output logic [DIV_W-1:0] active_div,
    output logic [31:0]      en_count
);

    clk_state_t       state, state_d;
    logic             counting;
    logic             tc;
    logic             strobe;
    logic             apply;
    logic             xfer;
    logic             pend_valid;
    logic [DIV_W-1:0] pend_div;

    clk_en_counter #(
        .DIV_W (DIV_W)
    ) u_counter (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (counting),
        .clr    (!counting || apply),
        .div    (active_div),
        .tc     (tc)
    );

    always_comb begin
        state_d  = state;
        counting = (state != HALTED);
        strobe   = counting && tc;
        // Halted applies a pending ratio straight away; otherwise wait for the period end.
        apply    = pend_valid && (!counting || strobe);
        xfer     = cfg_valid && !pend_valid;
        unique case (state)
            RUN: begin
                if (halt_req) state_d = HALTING;
            end
            HALTING: begin
                if (run_req && !halt_req) state_d = RUN;
                else if (tc)              state_d = HALTED;
            end
            HALTED: begin
                if (halt_req)      state_d = HALTED;
                else if (run_req)  state_d = RUN;
                else if (step_req) state_d = STEP;
            end
            STEP: begin
                if (run_req)  state_d = RUN;
                else if (tc)  state_d = HALTED;
            end
            default: state_d = state;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= START_RUN ? RUN : HALTED;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            clk_en     <= 1'b0;
            active_div <= DIV_W'(DEFAULT_DIV);
            pend_valid <= 1'b0;
            pend_div   <= '0;
            cfg_err    <= 1'b0;
            en_count   <= '0;
        end else begin
            clk_en <= strobe;
            if (strobe) en_count <= en_count + 32'd1;
            if (apply) begin
                active_div <= pend_div;
                pend_valid <= 1'b0;
            end
            // A zero ratio still completes the handshake but is dropped.
            if (xfer) begin
                if (cfg_div == '0) begin
                    cfg_err <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_div   <= cfg_div;
                end
            end
        end
    end

    assign cfg_ready = !pend_valid;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_clk_en_controller.sv
// Directed plus randomized bench for clk_en_controller against a period-countdown model.
module tb_clk_en_controller;

    localparam int unsigned DIV_W = 8;
    localparam int M_RUN = 0, M_HALTING = 1, M_HALTED = 2, M_STEP = 3;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             cfg_valid, halt_req, run_req, step_req;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready, cfg_err, clk_en, halted;
    logic [DIV_W-1:0] active_div;
    logic [31:0]      en_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: remaining cycles of the current period rather than a position counter.
    int          m_mode, m_left, m_div, m_pdiv;
    bit          m_pend, m_err, m_en;
    int unsigned m_cnt;

    clk_en_controller #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (2),
        .START_RUN   (1'b1)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .halt_req   (halt_req),
        .run_req    (run_req),
        .step_req   (step_req),
        .clk_en     (clk_en),
        .halted     (halted),
        .active_div (active_div),
        .en_count   (en_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".clk_en"},     32'(clk_en),     32'(m_en));
        check({tag, ".halted"},     32'(halted),     32'(m_mode == M_HALTED));
        check({tag, ".active_div"}, 32'(active_div), 32'(m_div));
        check({tag, ".en_count"},   en_count,        m_cnt);
        check({tag, ".cfg_ready"},  32'(cfg_ready),  32'(!m_pend));
        check({tag, ".cfg_err"},    32'(cfg_err),    32'(m_err));
    endtask

    task automatic model_reset();
        m_mode = M_RUN;
        m_div  = 2;
        m_left = 2;
        m_pdiv = 0;
        m_pend = 0;
        m_err  = 0;
        m_en   = 0;
        m_cnt  = 0;
    endtask

    task automatic model_tick();
        bit tc, apply, xfer, counting;
        int nmode;
        counting = (m_mode != M_HALTED);
        tc       = counting && (m_left == 1);
        apply    = m_pend && (!counting || tc);
        xfer     = cfg_valid && !m_pend;
        nmode    = m_mode;
        if (m_mode == M_RUN) begin
            if (halt_req) nmode = M_HALTING;
        end else if (m_mode == M_HALTING) begin
            if (run_req && !halt_req) nmode = M_RUN;
            else if (tc)              nmode = M_HALTED;
        end else if (m_mode == M_HALTED) begin
            if (!halt_req && run_req)                nmode = M_RUN;
            else if (!halt_req && step_req)          nmode = M_STEP;
        end else begin
            if (run_req)  nmode = M_RUN;
            else if (tc)  nmode = M_HALTED;
        end
        m_en = tc;
        if (tc) m_cnt++;
        if (apply) begin
            m_div  = m_pdiv;
            m_pend = 0;
        end
        if (xfer) begin
            if (cfg_div == 0) m_err = 1;
            else begin
                m_pend = 1;
                m_pdiv = int'(cfg_div);
            end
        end
        if (tc || !counting) m_left = m_div;
        else                 m_left--;
        m_mode = nmode;
    endtask

    task automatic cycle(input string tag);
        model_tick();
        @(posedge clk_in);
        @(negedge clk_in);
        check_all(tag);
    endtask

    task automatic cfg_write(input int d);
        cfg_valid = 1'b1;
        cfg_div   = DIV_W'(d);
        cycle("cfg");
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget && !cfg_ready; i++) cycle("wait_rdy");
        check("wait_ready_bound", 32'(cfg_ready), 32'd1);
    endtask

    task automatic wait_en(input int budget);
        for (int i = 0; i < budget && !clk_en; i++) cycle("wait_en");
        check("wait_en_bound", 32'(clk_en), 32'd1);
    endtask

    initial begin
        int unsigned base;
        int          strobes;
        rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0;
        halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
        model_reset();
        @(negedge clk_in);
        check("rst.clk_en", 32'(clk_en), 32'd0);
        check("rst.active_div", 32'(active_div), 32'd2);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk_in);
        rst = 1'b0;

        // 1: ratio 2 after reset
        for (int i = 0; i < 10; i++) cycle("t1");
        check("t1.en_count", en_count, 32'd5);
        check("t1.clk_en", 32'(clk_en), 32'd1);

        // 2: ratio change at period boundary
        cfg_write(4);
        wait_ready(10);
        wait_en(10);
        cycle("t2a");
        cfg_valid = 1'b1; cfg_div = 8'd3;
        cycle("t2b");
        cfg_valid = 1'b0;
        check("t2.ready_lo1", 32'(cfg_ready), 32'd0);
        cycle("t2c");
        check("t2.ready_lo2", 32'(cfg_ready), 32'd0);
        check("t2.no_strobe", 32'(clk_en), 32'd0);
        cycle("t2d");
        check("t2.ready_hi", 32'(cfg_ready), 32'd1);
        check("t2.old_tc_strobe", 32'(clk_en), 32'd1);
        check("t2.active_div", 32'(active_div), 32'd3);
        for (int i = 0; i < 6; i++) cycle("t2e");

        // 3: halt at cnt=0 with ratio 5
        cfg_write(5);
        wait_ready(10);
        wait_en(10);
        halt_req = 1'b1;
        cycle("t3a");
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) cycle("t3b");
        check("t3.pre_strobe", 32'(clk_en), 32'd0);
        cycle("t3c");
        check("t3.last_strobe", 32'(clk_en), 32'd1);
        check("t3.halted", 32'(halted), 32'd1);
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            cycle("t3d");
            strobes += int'(clk_en);
        end
        check("t3.quiet", 32'(strobes), 32'd0);

        // 4: single step with ratio 3
        cfg_write(3);
        cycle("t4a");
        check("t4.div3", 32'(active_div), 32'd3);
        base = en_count;
        step_req = 1'b1;
        cycle("t4b");
        step_req = 1'b0;
        cycle("t4c");
        cycle("t4d");
        check("t4.pre", 32'(clk_en), 32'd0);
        cycle("t4e");
        check("t4.strobe", 32'(clk_en), 32'd1);
        check("t4.halted", 32'(halted), 32'd1);
        check("t4.count", en_count, base + 32'd1);
        for (int i = 0; i < 6; i++) cycle("t4f");

        // 5: run+step together, then zero ratio
        run_req = 1'b1; step_req = 1'b1;
        cycle("t5a");
        run_req = 1'b0; step_req = 1'b0;
        check("t5.running", 32'(halted), 32'd0);
        for (int i = 0; i < 9; i++) cycle("t5b");
        cfg_write(0);
        cycle("t5c");
        check("t5.cfg_err", 32'(cfg_err), 32'd1);
        check("t5.div_kept", 32'(active_div), 32'd3);

        // 6: async reset with a ratio pending
        cfg_write(7);
        check("t6.pending", 32'(cfg_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("t6.clk_en", 32'(clk_en), 32'd0);
        check("t6.cfg_ready", 32'(cfg_ready), 32'd1);
        check("t6.cfg_err", 32'(cfg_err), 32'd0);
        check("t6.en_count", en_count, 32'd0);
        check("t6.active_div", 32'(active_div), 32'd2);
        @(negedge clk_in);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) cycle("t6b");
        check("t6.not_applied", 32'(active_div), 32'd2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            halt_req  = ($urandom_range(0, 15) == 0);
            run_req   = ($urandom_range(0, 15) == 0);
            step_req  = ($urandom_range(0, 7) == 0);
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_div   = DIV_W'($urandom_range(0, 6));
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
